// File: rtl/packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : packer_pkg
// Purpose  : Shared widths, byte type and count-width helper for the
//            byte-to-word packer.
// Revision : 1.0 - initial release
// ============================================================================
package packer_pkg;

    localparam int BYTE_W             = 8;
    localparam int BYTES_PER_WORD_DEF = 4;

    typedef logic [BYTE_W-1:0] byte_t;

    // Width able to hold the values 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/packer_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : packer_out_reg
// Purpose  : Single-entry valid/ready output register for packed words.
//            Optional parity storage under BYTE_WORD_PACKER_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module packer_out_reg #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 3
`ifdef BYTE_WORD_PACKER_PARITY_EN
    ,
    parameter int LANES  = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_bytes,
`ifdef BYTE_WORD_PACKER_PARITY_EN
    input  logic [LANES-1:0]  load_parity,
    output logic [LANES-1:0]  out_parity,
`endif
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_bytes
);

    // The parent only asserts load when the slot is empty or draining, so a
    // load always wins over a retire on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_bytes  <= '0;
`ifdef BYTE_WORD_PACKER_PARITY_EN
            out_parity <= '0;
`endif
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= load_data;
            out_bytes  <= load_bytes;
`ifdef BYTE_WORD_PACKER_PARITY_EN
            out_parity <= load_parity;
`endif
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_word_packer
// Purpose  : Packs a valid/ready byte stream little-endian into words, with
//            flush of partial words. Macro BYTE_WORD_PACKER_PARITY_EN adds
//            per-lane even parity output out_parity.
// Revision : 1.0 - initial release
// ============================================================================
module byte_word_packer
    import packer_pkg::*;
#(
    parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
    parameter int DATA_W         = BYTE_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [DATA_W-1:0]                   in_data,
    output logic                                in_ready,
    input  logic                                flush,
    output logic                                out_valid,
    output logic [DATA_W*BYTES_PER_WORD-1:0]    out_data,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0] out_bytes,
`ifdef BYTE_WORD_PACKER_PARITY_EN
    output logic [BYTES_PER_WORD-1:0]           out_parity,
`endif
    input  logic                                out_ready
);

    localparam int                 c_CNT_W  = cnt_w(BYTES_PER_WORD);
    localparam int                 c_WORD_W = DATA_W * BYTES_PER_WORD;
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(BYTES_PER_WORD);

    logic [c_CNT_W-1:0]  r_count;
    logic [c_WORD_W-1:0] r_acc;
    logic                r_flush_pend;

    logic                w_slot_free;
    logic                w_blocked;
    logic                w_accept;
    logic                w_complete;
    logic                w_flush_go;
    logic                w_load;
    logic [c_WORD_W-1:0] w_merged;
    logic [c_CNT_W-1:0]  w_load_bytes;

    assign w_slot_free = !out_valid || out_ready;
    // A pending flush that cannot yet emit freezes the partial word.
    assign w_blocked   = r_flush_pend && (r_count != '0) && !w_slot_free;
    assign in_ready    = !w_blocked && ((r_count != c_LAST) || w_slot_free);
    assign w_accept    = in_valid && in_ready;
    assign w_complete  = w_accept && (r_count == c_LAST);
    assign w_flush_go  = r_flush_pend && (r_count != '0) && w_slot_free;
    assign w_load      = w_complete || w_flush_go;

    // Accumulator with this cycle's byte already placed in its lane, so a
    // flush executing alongside an accept includes that byte.
    always_comb begin
        w_merged = r_acc;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (w_accept && (r_count == c_CNT_W'(i))) begin
                w_merged[i*DATA_W +: DATA_W] = in_data;
            end
        end
    end

    assign w_load_bytes = w_complete ? c_FULL
                                     : r_count + {{(c_CNT_W-1){1'b0}}, w_accept};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_acc        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_load) begin
                r_count <= '0;
                r_acc   <= '0;
            end else if (w_accept) begin
                r_count <= r_count + c_CNT_W'(1);
                r_acc   <= w_merged;
            end

            if (flush && !w_complete) begin
                r_flush_pend <= 1'b1;
            end else if (w_complete || w_flush_go || (r_count == '0)) begin
                r_flush_pend <= 1'b0;
            end
        end
    end

`ifdef BYTE_WORD_PACKER_PARITY_EN
    logic [BYTES_PER_WORD-1:0] w_parity;

    for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_parity
        byte_t w_lane;
        assign w_lane      = w_merged[g*DATA_W +: DATA_W];
        assign w_parity[g] = ^w_lane;
    end
`endif

    packer_out_reg #(
        .WORD_W     (c_WORD_W),
        .CNT_W      (c_CNT_W)
`ifdef BYTE_WORD_PACKER_PARITY_EN
        ,
        .LANES      (BYTES_PER_WORD)
`endif
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .load_data  (w_merged),
        .load_bytes (w_load_bytes),
`ifdef BYTE_WORD_PACKER_PARITY_EN
        .load_parity(w_parity),
        .out_parity (out_parity),
`endif
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_bytes  (out_bytes)
    );

endmodule
`default_nettype wire

// File: tb/tb_byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_word_packer
// Purpose  : Directed self-checking bench for byte_word_packer (4 bytes/word).
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_word_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_ready;
`ifdef BYTE_WORD_PACKER_PARITY_EN
    logic [3:0]  out_parity;
`endif

    int n_vec;
    int n_err;

    byte_word_packer #(
        .BYTES_PER_WORD(4),
        .DATA_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_bytes (out_bytes),
`ifdef BYTE_WORD_PACKER_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string name, input logic [31:0] exp_data,
                            input logic [2:0] exp_bytes);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== exp_data || out_bytes !== exp_bytes) begin
            n_err++;
            $display("FAIL %s: valid=%b data=%h bytes=%0d, want valid=1 data=%h bytes=%0d",
                     name, out_valid, out_data, out_bytes, exp_data, exp_bytes);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_bytes !== 3'd0) begin
            n_err++;
            $display("FAIL reset_out: valid=%b data=%h bytes=%0d, want 0/0/0",
                     out_valid, out_data, out_bytes);
        end
        rst = 1'b0;
        #1;
        chk_bit("reset_in_ready", in_ready, 1'b1);
    endtask

    task automatic test_fill;
        out_ready = 1'b1;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        chk_bit("fill_no_early_valid", out_valid, 1'b0);
        send(8'h44);
        chk_word("fill_word", 32'h44332211, 3'd4);
        tick();
        chk_bit("fill_one_cycle", out_valid, 1'b0);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int b = 1; b <= 7; b++) begin
            in_valid = 1'b1;
            in_data  = 8'(b);
            #0;
            chk_bit("bp_ready_pre", in_ready, 1'b1);
            tick();
        end
        chk_word("bp_held", 32'h04030201, 3'd4);
        in_data = 8'h08;
        #1;
        chk_bit("bp_stall_last", in_ready, 1'b0);
        tick();
        chk_word("bp_stable", 32'h04030201, 3'd4);
        out_ready = 1'b1;
        #1;
        chk_bit("bp_ready_on_drain", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_word("bp_back_to_back", 32'h08070605, 3'd4);
        tick();
        chk_bit("bp_drained", out_valid, 1'b0);
    endtask

    task automatic test_partial_flush;
        out_ready = 1'b1;
        send(8'hAA);
        send(8'hBB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_bit("pf_pending", out_valid, 1'b0);
        tick();
        chk_word("pf_word", 32'h0000BBAA, 3'd2);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        chk_word("pf_next_lane0", 32'h04030201, 3'd4);
        tick();
    endtask

    task automatic test_flush_edges;
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_bit("fe_empty_flush", out_valid, 1'b0);
            tick();
        end
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        flush = 1'b1;
        send(8'hDD);
        flush = 1'b0;
        chk_word("fe_flush_with_last", 32'hDDCCBBAA, 3'd4);
        tick();
        chk_bit("fe_no_empty_word1", out_valid, 1'b0);
        tick();
        chk_bit("fe_no_empty_word2", out_valid, 1'b0);
    endtask

    task automatic test_blocked_flush;
        out_ready = 1'b0;
        send(8'h10);
        send(8'h20);
        send(8'h30);
        send(8'h40);
        send(8'h55);
        chk_word("bf_held", 32'h40302010, 3'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h66;
        #1;
        chk_bit("bf_blocked1", in_ready, 1'b0);
        tick();
        chk_bit("bf_blocked2", in_ready, 1'b0);
        chk_word("bf_still_held", 32'h40302010, 3'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_word("bf_partial", 32'h00000055, 3'd1);
        tick();
        chk_bit("bf_drained", out_valid, 1'b0);
        chk_bit("bf_ready_back", in_ready, 1'b1);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        send(8'hE1);
        send(8'hE2);
        send(8'hE3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_bit("rm_valid_low", out_valid, 1'b0);
        chk_bit("rm_ready", in_ready, 1'b1);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        chk_word("rm_clean_word", 32'h04030201, 3'd4);
        tick();
        out_ready = 1'b0;
        send(8'hF1);
        send(8'hF2);
        send(8'hF3);
        send(8'hF4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_bit("rm_held_discard", out_valid, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_bit("rm_no_ghost", out_valid, 1'b0);
    endtask

`ifdef BYTE_WORD_PACKER_PARITY_EN
    task automatic test_parity;
        out_ready = 1'b1;
        send(8'h00);
        send(8'h01);
        send(8'h03);
        send(8'h07);
        chk_word("par_word", 32'h07030100, 3'd4);
        n_vec++;
        if (out_parity !== 4'b1010) begin
            n_err++;
            $display("FAIL par_bits: got %b, want 1010", out_parity);
        end
        tick();
    endtask
`endif

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_fill();
        test_backpressure();
        test_partial_flush();
        test_flush_edges();
        test_blocked_flush();
        test_reset_mid();
`ifdef BYTE_WORD_PACKER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Downstream stage of the 8-bit registered data path; consumes the registered byte stream and packs consecutive bytes into wide words for the word-oriented sink.
- Little-endian packing: first byte lands in bits [7:0].
- Valid/ready handshake on both sides. Single-entry output register, so a full word can wait on backpressure while the next word starts filling.

Parameters:
- BYTES_PER_WORD, 4, bytes per output word; legal range 2..8.
- DATA_W, 8, byte width; fixed to match the upstream byte path.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  DATA_W  upstream byte.
- in_ready  output  1  packer accepts in_data this cycle.
- flush  input  1  one-cycle pulse: emit the partial word.
- out_valid  output  1  out_data/out_bytes valid.
- out_data  output  DATA_W*BYTES_PER_WORD  packed word.
- out_bytes  output  $clog2(BYTES_PER_WORD+1)  count of valid bytes in out_data (1..BYTES_PER_WORD).
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (sync, rst high at clk edge): out_valid=0, out_data=0, out_bytes=0, fill count=0, accumulator=0, flush_pend=0. in_ready is combinational and reads 1 after reset.
- Byte accept: in_valid && in_ready. Write the byte into accumulator lane [count], then count++.
- in_ready = (count != BYTES_PER_WORD-1) || !out_valid || out_ready. Only the completing byte is stalled by a full, undrained output register.
- Word complete: on accept with count == BYTES_PER_WORD-1, on the same edge:
  - out_data <= {byte, accumulator lanes}
  - out_bytes <= BYTES_PER_WORD
  - out_valid <= 1
  - count <= 0, accumulator <= 0
- Latency: last byte accepted at edge N gives out_valid=1 after edge N.
- Output handshake: out_valid && out_ready retires the word; out_valid clears next edge unless a new word loads on that same edge. A simultaneous retire and load is back-to-back, with no bubble.
- out_data and out_bytes stay stable while out_valid && !out_ready.
- Flush:
  - A flush pulse sets flush_pend.
  - flush_pend executes when the output slot is free or draining (!out_valid || out_ready) and count > 0. It loads the partial word with upper lanes zero, sets out_bytes = count, resets count, and clears flush_pend.
  - flush_pend with count == 0 clears without emitting anything.
  - Flush in the same cycle as a byte accept: the byte is included first. If that byte completes the word, the full word is emitted and flush_pend clears, since there is no empty word.
  - While flush_pend is set and blocked, in_ready = 0 so the partial word cannot grow.
- Reset mid-operation: partial accumulator and the pending output word are discarded. No output is emitted for them.
- Counter wraps only through word completion or flush; count never reaches BYTES_PER_WORD.

Optional Feature:
- Macro: BYTE_WORD_PACKER_PARITY_EN.
- Defined: adds output port out_parity [BYTES_PER_WORD-1:0].
  - Bit i is the even-parity bit (XOR) of byte lane i, registered with out_data.
  - Zero-padded lanes give parity 0.
  - Reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- packer_pkg holds:
  - BYTE_W = 8 and the default BYTES_PER_WORD = 4.
  - Function cnt_w(n) = $clog2(n+1).
  - typedef byte_t (logic [7:0]).
- One sub-module is natural: packer_out_reg, the single-entry valid/ready output register holding data, bytes and optional parity.
- Accumulator, counter and flush logic stay in the top module.

Test Plan:
- Fill: out_ready=1; bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> one cycle after the 4th accept, out_data=0x44332211, out_bytes=4, out_valid=1 for exactly 1 cycle.
- Backpressure: out_ready=0; bytes 0x01..0x08 streamed continuously -> word 0x04030201 held. Bytes 5–7 accepted, in_ready=0 on byte 8. Raising out_ready retires the word, byte 8 is accepted on the same edge, then 0x08070605 appears with no bubble.
- Partial flush: bytes 0xAA,0xBB then flush -> out_data=0x0000BBAA, out_bytes=2; next word starts at lane 0.
- Flush edge cases:
  - flush with count=0 -> no out_valid.
  - flush together with the 4th byte 0xDD after 0xAA,0xBB,0xCC -> single word 0xDDCCBBAA, out_bytes=4, no empty word.
- Blocked flush: out_valid held with out_ready=0, count=1, flush pulse -> in_ready=0 until out_ready rises. The partial word then follows with out_bytes=1.
- Reset mid-word: 3 bytes accepted, rst for 1 cycle -> out_valid=0. The next 4 bytes 0x01..0x04 give 0x04030201.
- With BYTE_WORD_PACKER_PARITY_EN: word 0x07030100 -> out_parity=4'b1010.
